// File: rtl/nibble_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : nibble_serial_adder_ctrl
// Purpose  : Sequences a wide addition through an external combinational
//            4-bit adder, one nibble per cycle, LS nibble first. The carry is
//            chained through a register, and the assembled sum is offered on
//            a valid/ready result port.
// Ports    : clk, rst             - clock, asynchronous active-high reset
//            start_valid/ready    - operand handshake (op_a, op_b, op_cin)
//            add_a/b/cin          - drive the external 4-bit adder
//            add_sum/cout         - returned by the external 4-bit adder
//            res_valid/ready      - result handshake (res_sum/cout/ovf)
//            busy                 - high while nibbles are being added
// Revision : 1.0 - initial release
// ============================================================================
module nibble_serial_adder_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_valid,
  output logic                   start_ready,
  input  logic [4*NIBBLES-1:0]   op_a,
  input  logic [4*NIBBLES-1:0]   op_b,
  input  logic                   op_cin,
  output logic [3:0]             add_a,
  output logic [3:0]             add_b,
  output logic                   add_cin,
  input  logic [3:0]             add_sum,
  input  logic                   add_cout,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [4*NIBBLES-1:0]   res_sum,
  output logic                   res_cout,
  output logic                   res_ovf,
  output logic                   busy
);

  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = $clog2(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nx;

  logic [W-1:0]       r_a;
  logic [W-1:0]       r_b;
  logic               r_carry;
  logic [IDX_W-1:0]   r_idx;
  logic [W-1:0]       r_sum;
  logic               r_cout;
  logic               r_ovf;

  logic               w_last;
  logic [W-1:0]       w_a_shift;
  logic [W-1:0]       w_b_shift;

  assign w_last    = (r_idx == LAST_IDX);
  // Shift the selected nibble down to bit 0 (shift amount = 4*idx).
  assign w_a_shift = r_a >> {r_idx, 2'b00};
  assign w_b_shift = r_b >> {r_idx, 2'b00};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Next state and outputs
  always_comb begin
    w_state_nx  = r_state;
    start_ready = 1'b0;
    res_valid   = 1'b0;
    busy        = 1'b0;
    add_a       = 4'd0;
    add_b       = 4'd0;
    add_cin     = 1'b0;
    case (r_state)
      S_IDLE: begin
        start_ready = 1'b1;
        if (start_valid) begin
          w_state_nx = S_ADD;
        end
      end
      S_ADD: begin
        busy    = 1'b1;
        add_a   = w_a_shift[3:0];
        add_b   = w_b_shift[3:0];
        add_cin = r_carry;
        if (w_last) begin
          w_state_nx = S_DONE;
        end
      end
      S_DONE: begin
        res_valid = 1'b1;
        if (res_ready) begin
          w_state_nx = S_IDLE;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  // Datapath: operand capture, per-nibble result capture, carry chaining
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_valid) begin
            r_a     <= op_a;
            r_b     <= op_b;
            r_carry <= op_cin;
            r_idx   <= '0;
            r_sum   <= '0;
          end
        end
        S_ADD: begin
          for (int i = 0; i < NIBBLES; i++) begin
            if (r_idx == IDX_W'(i)) begin
              r_sum[4*i +: 4] <= add_sum;
            end
          end
          r_carry <= add_cout;
          if (w_last) begin
            // Overflow: like-signed operands producing a differently signed
            // top nibble.
            r_cout <= add_cout;
            r_ovf  <= (r_a[W-1] == r_b[W-1]) && (add_sum[3] != r_a[W-1]);
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign res_sum  = r_sum;
  assign res_cout = r_cout;
  assign res_ovf  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_nibble_serial_adder_ctrl
// Purpose  : Directed self-checking bench for nibble_serial_adder_ctrl with a
//            behavioural 4-bit adder closing the loop.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nibble_serial_adder_ctrl;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_valid;
  logic          start_ready;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  logic          op_cin;
  logic [3:0]    add_a;
  logic [3:0]    add_b;
  logic          add_cin;
  logic [3:0]    add_sum;
  logic          add_cout;
  logic          res_valid;
  logic          res_ready;
  logic [W-1:0]  res_sum;
  logic          res_cout;
  logic          res_ovf;
  logic          busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // External combinational 4-bit adder
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_cin};

  nibble_serial_adder_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .op_a        (op_a),
    .op_b        (op_b),
    .op_cin      (op_cin),
    .add_a       (add_a),
    .add_b       (add_b),
    .add_cin     (add_cin),
    .add_sum     (add_sum),
    .add_cout    (add_cout),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_sum     (res_sum),
    .res_cout    (res_cout),
    .res_ovf     (res_ovf),
    .busy        (busy)
  );

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full operation. a_seq/cin_seq collect add_a / add_cin per ADD cycle,
  // nibble 0 in the most significant position of the packed result.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic [W-1:0] exp_sum,
                        input logic exp_cout, input logic exp_ovf, input bit hold_ready,
                        output logic [15:0] a_seq, output logic [3:0] cin_seq);
    int n;
    a_seq   = '0;
    cin_seq = '0;
    op_a        = a;
    op_b        = b;
    op_cin      = cin;
    start_valid = 1'b1;
    n = 0;
    while (!start_ready && n < 20) begin
      step();
      n++;
    end
    if (!start_ready) chk_eq({tag, "_accept_timeout"}, start_ready, 1);
    step();
    start_valid = 1'b0;
    n = 0;
    while (!res_valid && n < 20) begin
      a_seq   = {a_seq[11:0], add_a};
      cin_seq = {cin_seq[2:0], add_cin};
      step();
      n++;
    end
    chk_eq({tag, "_latency"}, n, NIBBLES);
    chk_eq({tag, "_sum"},  res_sum,  exp_sum);
    chk_eq({tag, "_cout"}, res_cout, exp_cout);
    chk_eq({tag, "_ovf"},  res_ovf,  exp_ovf);
    res_ready = 1'b1;
    step();
    if (!hold_ready) res_ready = 1'b0;
    chk_eq({tag, "_ready_after"}, start_ready, 1);
  endtask

  logic [15:0] aseq;
  logic [3:0]  cseq;

  initial begin
    rst         = 1'b1;
    start_valid = 1'b0;
    op_a        = '0;
    op_b        = '0;
    op_cin      = 1'b0;
    res_ready   = 1'b0;
    step();
    step();
    chk_eq("rst_start_ready", start_ready, 1);
    chk_eq("rst_res_valid",   res_valid,   0);
    chk_eq("rst_busy",        busy,        0);
    chk_eq("rst_add",         {add_a, add_b, add_cin}, 0);
    chk_eq("rst_res",         {res_sum, res_cout, res_ovf}, 0);
    rst = 1'b0;
    step();

    // Basic vectors
    run_op("t1", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, aseq, cseq);
    chk_eq("t1_add_a_seq", aseq, 16'h4321);
    run_op("t2", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, aseq, cseq);
    chk_eq("t2_cin_seq", cseq, 4'b0111);
    run_op("t3", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, aseq, cseq);
    run_op("t4", 16'h00FF, 16'h0000, 1'b1, 16'h0100, 1'b0, 1'b0, 1'b0, aseq, cseq);
    run_op("t5", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, aseq, cseq);

    // Backpressure: result held while new operands wait
    op_a = 16'h1111; op_b = 16'h2222; op_cin = 1'b0;
    start_valid = 1'b1;
    step();
    start_valid = 1'b0;
    repeat (NIBBLES) step();
    chk_eq("bp_valid", res_valid, 1);
    op_a = 16'hAAAA; op_b = 16'h5555; op_cin = 1'b1;
    start_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_eq("bp_sum_hold",   res_sum,     16'h3333);
      chk_eq("bp_ready_low",  start_ready, 0);
      chk_eq("bp_valid_hold", res_valid,   1);
      chk_eq("bp_add_idle",   {add_a, add_b, add_cin}, 0);
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk_eq("bp_ready_back", start_ready, 1);
    chk_eq("bp_valid_drop", res_valid,   0);
    step();
    start_valid = 1'b0;
    chk_eq("bp_busy", busy, 1);
    chk_eq("bp_first_a", add_a, 4'hA);
    chk_eq("bp_first_b", add_b, 4'h5);
    chk_eq("bp_first_cin", add_cin, 1);
    repeat (NIBBLES) step();
    chk_eq("bp_new_valid", res_valid, 1);
    chk_eq("bp_new_sum",   res_sum,   16'h0000);
    chk_eq("bp_new_cout",  res_cout,  1);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;

    // Asynchronous reset mid-operation
    op_a = 16'h0123; op_b = 16'h0456; op_cin = 1'b0;
    start_valid = 1'b1;
    step();
    start_valid = 1'b0;
    step();
    step();
    chk_eq("abort_busy_before", busy, 1);
    #2;
    rst = 1'b1;
    #1;
    chk_eq("abort_start_ready", start_ready, 1);
    chk_eq("abort_res_valid",   res_valid,   0);
    chk_eq("abort_busy",        busy,        0);
    chk_eq("abort_add",         {add_a, add_b, add_cin}, 0);
    chk_eq("abort_res_sum",     res_sum,     0);
    step();
    rst = 1'b0;
    step();
    chk_eq("abort_no_valid", res_valid, 0);
    run_op("fresh", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, aseq, cseq);

    // Back-to-back with res_ready held high
    res_ready = 1'b1;
    run_op("b2b0", 16'h0F0F, 16'h0101, 1'b0, 16'h1010, 1'b0, 1'b0, 1'b1, aseq, cseq);
    run_op("b2b1", 16'h9999, 16'h9999, 1'b1, 16'h3333, 1'b1, 1'b1, 1'b1, aseq, cseq);
    run_op("b2b2", 16'h4000, 16'h4000, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1, aseq, cseq);
    res_ready = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
